demapper_16_qam_chk: RTL

DEMAPPER_16_QAM_CHK -- requirements
Module: demapper_16_qam_chk

---
 rtl/demapper_16_qam_chk.sv | 137 +++++++++++++
 1 files changed

// File: rtl/demapper_16_qam_chk.sv
// 16-QAM hard-decision slicer with windowed symbol/bit error counting against a delayed reference.
// Build macro DEMAP_BIT_ERR_COUNT_EN adds the bit-error counter; without it bit_err_out is 0.
module demapper_16_qam_chk #(
   parameter int REF_DELAY   = 4,
   parameter int CNT_W       = 22,
   parameter int LOCK_THRESH = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clk_en,
   input  logic signed [17:0]  in_phs_dec,
   input  logic signed [17:0]  quad_dec,
   input  logic [17:0]         ref_level,
   input  logic [3:0]          ref_sym,
   input  logic                period,
   output logic [3:0]          sym_out,
   output logic [CNT_W-1:0]    sym_cnt_out,
   output logic [CNT_W-1:0]    sym_err_out,
   output logic [CNT_W-1:0]    bit_err_out,
   output logic                result_valid,
   output logic                locked
);

   typedef enum logic {WAIT, RUN} state_t;

   localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(LOCK_THRESH);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   state_t           state_reg, state_next;
   logic [3:0]       ref_dly [REF_DELAY];
   logic [3:0]       diff;
   logic             sym_err;
   logic             reload, accum, publish;
   logic [CNT_W-1:0] cnt_reg, cnt_next, serr_reg, serr_next;

   function automatic logic [1:0] slice(input logic signed [17:0] x, input logic [17:0] lvl);
      logic signed [18:0] xs, t;
      xs = {x[17], x};
      t  = signed'({1'b0, lvl});
      if (xs < -t)
         return 2'b00;
      else if (xs < 19'sd0)
         return 2'b01;
      else if (xs < t)
         return 2'b11;
      else
         return 2'b10;
   endfunction

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [2:0] b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + (CNT_W+1)'(b);
      return s[CNT_W] ? '1 : s[CNT_W-1:0];
   endfunction

   assign diff    = sym_out ^ ref_dly[REF_DELAY-1];
   assign sym_err = |diff;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      serr_next  = serr_reg;
      reload     = clk_en && period;
      accum      = clk_en && !period && (state_reg == RUN);
      publish    = reload && (state_reg == RUN);
      if (reload) begin
         state_next = RUN;
         cnt_next   = ONE;
         serr_next  = CNT_W'(sym_err);
      end else if (accum) begin
         cnt_next   = sat_add(cnt_reg, 3'd1);
         serr_next  = sat_add(serr_reg, {2'b00, sym_err});
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= WAIT;
         sym_out      <= '0;
         cnt_reg      <= '0;
         serr_reg     <= '0;
         sym_cnt_out  <= '0;
         sym_err_out  <= '0;
         result_valid <= 1'b0;
         locked       <= 1'b0;
         for (int i = 0; i < REF_DELAY; i++)
            ref_dly[i] <= '0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         serr_reg     <= serr_next;
         result_valid <= publish;
         if (clk_en) begin
            sym_out    <= {slice(in_phs_dec, ref_level), slice(quad_dec, ref_level)};
            ref_dly[0] <= ref_sym;
            for (int i = 1; i < REF_DELAY; i++)
               ref_dly[i] <= ref_dly[i-1];
         end
         // Published counts exclude the symbol on the marker edge itself.
         if (publish) begin
            sym_cnt_out <= cnt_reg;
            sym_err_out <= serr_reg;
            locked      <= (serr_reg <= LOCK_LIM);
         end
      end
   end

`ifdef DEMAP_BIT_ERR_COUNT_EN
   logic [2:0]       bit_err;
   logic [CNT_W-1:0] berr_reg, berr_next;

   assign bit_err = 3'(diff[0]) + 3'(diff[1]) + 3'(diff[2]) + 3'(diff[3]);

   always_comb begin
      berr_next = berr_reg;
      if (reload)
         berr_next = CNT_W'(bit_err);
      else if (accum)
         berr_next = sat_add(berr_reg, bit_err);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         berr_reg    <= '0;
         bit_err_out <= '0;
      end else begin
         berr_reg <= berr_next;
         if (publish)
            bit_err_out <= berr_reg;
      end
   end
`else
   assign bit_err_out = '0;
`endif

endmodule
